// File: rtl/spike_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spike_event_fifo
// Description : First-word-fall-through queue for spike event addresses sitting
//               between the input spike interface and synapse_mem_ctrl.
//               Ready/valid handshakes on both sides, full / empty /
//               almost-full flags, occupancy count, synchronous flush and an
//               optional drop-on-full mode with a saturating drop counter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH      width of one spike event address
//   DEPTH           number of entries (power of 2, >= 2)
//   AFULL_THRESH    o_almost_full asserts when count >= this (1..DEPTH)
//   DROP_ON_FULL    0: back-pressure writer when full
//                   1: always ready, discard writes that find the queue full
//   DROP_CNT_WIDTH  width of the saturating drop counter
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   synchronous active-low reset
//   i_flush        in   discard all stored entries
//   i_wr_valid     in   write request
//   i_wr_data      in   write address
//   o_wr_ready     out  write accepted when i_wr_valid & o_wr_ready
//   o_rd_valid     out  head entry present
//   o_rd_data      out  head entry, 0 when empty
//   i_rd_ready     in   pop head when o_rd_valid & i_rd_ready
//   o_count        out  occupancy 0..DEPTH
//   o_full         out  count == DEPTH
//   o_empty        out  count == 0
//   o_almost_full  out  count >= AFULL_THRESH
//   o_drop_cnt     out  writes discarded while full (drop mode only)
// ============================================================================
module spike_event_fifo #(
    parameter int DATA_WIDTH     = 14,
    parameter int DEPTH          = 128,
    parameter int AFULL_THRESH   = 112,
    parameter int DROP_ON_FULL   = 0,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_flush,
    input  logic                          i_wr_valid,
    input  logic [DATA_WIDTH-1:0]         i_wr_data,
    output logic                          o_wr_ready,
    output logic                          o_rd_valid,
    output logic [DATA_WIDTH-1:0]         o_rd_data,
    input  logic                          i_rd_ready,
    output logic [$clog2(DEPTH):0]        o_count,
    output logic                          o_full,
    output logic                          o_empty,
    output logic                          o_almost_full,
    output logic [DROP_CNT_WIDTH-1:0]     o_drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] C_DEPTH  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_AFULL  = CNT_W'(AFULL_THRESH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [CNT_W-1:0]          r_count;
    logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Status is derived from registered state only, so no input ever reaches
    // an output combinationally.
    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);

    // A pop can only happen when something is stored; a write arriving at an
    // empty queue is therefore never bypassed to the read side.
    assign w_pop = ~w_empty & i_rd_ready;

    // ------------------------------------------------------------------
    // Full-handling mode
    // ------------------------------------------------------------------
    generate
        if (DROP_ON_FULL != 0) begin : g_drop_mode
            // Always ready. When full, a write that coincides with a pop
            // takes the freed slot; otherwise it is discarded and counted.
            assign o_wr_ready = 1'b1;
            assign w_push     = i_wr_valid & (~w_full | w_pop);
            assign w_drop     = i_wr_valid & w_full & ~w_pop;
        end else begin : g_stall_mode
            // Ready is the registered not-full flag; a pop in the same cycle
            // does not open the slot for a write until the next cycle.
            assign o_wr_ready = ~w_full;
            assign w_push     = i_wr_valid & ~w_full;
            assign w_drop     = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pointers, occupancy and drop counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
        end else if (i_flush) begin
            // Flush empties the queue and ignores this cycle's handshakes,
            // but the drop history is kept for diagnostics.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers wrap DEPTH-1 -> 0 by natural overflow (DEPTH is 2^n).
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Saturate at all-ones rather than wrapping back to zero.
            if (w_drop && (r_drop_cnt != {DROP_CNT_WIDTH{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage (not reset; contents are qualified by the occupancy count)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n && !i_flush && w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_rd_valid    = ~w_empty;
    assign o_rd_data     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count       = r_count;
    assign o_full        = w_full;
    assign o_empty       = w_empty;
    assign o_almost_full = (r_count >= C_AFULL);
    assign o_drop_cnt    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_spike_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_spike_event_fifo
// Description : Directed bench for spike_event_fifo. Two instances (stall mode
//               and drop mode, DEPTH=4, AFULL_THRESH=3) share one stimulus
//               stream; each step checks both against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_event_fifo;

    localparam int DW = 14;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          rd_ready;

    logic          wr_ready0, rd_valid0, full0, empty0, af0;
    logic [DW-1:0] rd_data0;
    logic [2:0]    count0;
    logic [15:0]   drop0;

    logic          wr_ready1, rd_valid1, full1, empty1, af1;
    logic [DW-1:0] rd_data1;
    logic [2:0]    count1;
    logic [15:0]   drop1;

    int n_tests;
    int n_fail;

    spike_event_fifo #(
        .DATA_WIDTH(DW), .DEPTH(4), .AFULL_THRESH(3),
        .DROP_ON_FULL(0), .DROP_CNT_WIDTH(16)
    ) u_stall (
        .clk(clk), .rst_n(rst_n), .i_flush(flush),
        .i_wr_valid(wr_valid), .i_wr_data(wr_data), .o_wr_ready(wr_ready0),
        .o_rd_valid(rd_valid0), .o_rd_data(rd_data0), .i_rd_ready(rd_ready),
        .o_count(count0), .o_full(full0), .o_empty(empty0),
        .o_almost_full(af0), .o_drop_cnt(drop0)
    );

    spike_event_fifo #(
        .DATA_WIDTH(DW), .DEPTH(4), .AFULL_THRESH(3),
        .DROP_ON_FULL(1), .DROP_CNT_WIDTH(16)
    ) u_drop (
        .clk(clk), .rst_n(rst_n), .i_flush(flush),
        .i_wr_valid(wr_valid), .i_wr_data(wr_data), .o_wr_ready(wr_ready1),
        .o_rd_valid(rd_valid1), .o_rd_data(rd_data1), .i_rd_ready(rd_ready),
        .o_count(count1), .o_full(full1), .o_empty(empty1),
        .o_almost_full(af1), .o_drop_cnt(drop1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_cnt0"},   32'(count0),    32'd0);
        chk({tag, "_cnt1"},   32'(count1),    32'd0);
        chk({tag, "_empty0"}, 32'(empty0),    32'd1);
        chk({tag, "_empty1"}, 32'(empty1),    32'd1);
        chk({tag, "_full0"},  32'(full0),     32'd0);
        chk({tag, "_af1"},    32'(af1),       32'd0);
        chk({tag, "_vld0"},   32'(rd_valid0), 32'd0);
        chk({tag, "_data1"},  32'(rd_data1),  32'd0);
        chk({tag, "_rdy0"},   32'(wr_ready0), 32'd1);
        chk({tag, "_rdy1"},   32'(wr_ready1), 32'd1);
        chk({tag, "_drop1"},  32'(drop1),     32'd0);
    endtask

    initial begin
        logic [DW-1:0] exp0 [4];
        logic [DW-1:0] exp1 [4];
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        step();
        step();
        chk_reset_state("reset");
        rst_n = 1'b1;

        // ---- 1: three writes, almost-full, in-order pops ----
        wr_valid = 1'b1;
        wr_data = 14'h0011; step();
        chk("t1_lat_vld0", 32'(rd_valid0), 32'd1);
        chk("t1_lat_data0", 32'(rd_data0), 32'h11);
        wr_data = 14'h0022; step();
        chk("t1_af_at2", 32'(af0), 32'd0);
        wr_data = 14'h0033; step();
        wr_valid = 1'b0;
        chk("t1_cnt0", 32'(count0), 32'd3);
        chk("t1_cnt1", 32'(count1), 32'd3);
        chk("t1_af0", 32'(af0), 32'd1);
        chk("t1_af1", 32'(af1), 32'd1);
        rd_ready = 1'b1;
        chk("t1_pop0_a", 32'(rd_data0), 32'h11); step();
        chk("t1_pop0_b", 32'(rd_data0), 32'h22);
        chk("t1_pop1_b", 32'(rd_data1), 32'h22); step();
        chk("t1_pop0_c", 32'(rd_data0), 32'h33); step();
        rd_ready = 1'b0;
        chk("t1_empty0", 32'(empty0), 32'd1);
        chk("t1_empty1", 32'(empty1), 32'd1);
        chk("t1_data_empty", 32'(rd_data0), 32'd0);

        // ---- 2/3: six writes, no pops ----
        wr_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = DW'(14'h101 + i);
            step();
            if (i == 3) begin
                chk("t2_full0_after4", 32'(full0), 32'd1);
                chk("t2_rdy0_after4", 32'(wr_ready0), 32'd0);
                chk("t3_rdy1_after4", 32'(wr_ready1), 32'd1);
            end
        end
        wr_valid = 1'b0;
        chk("t2_cnt0", 32'(count0), 32'd4);
        chk("t2_drop0", 32'(drop0), 32'd0);
        chk("t3_cnt1", 32'(count1), 32'd4);
        chk("t3_drop1", 32'(drop1), 32'd2);
        chk("t3_head1", 32'(rd_data1), 32'h101);

        // ---- 4: full + simultaneous write and pop ----
        wr_valid = 1'b1; wr_data = 14'h1AA; rd_ready = 1'b1;
        step();
        wr_valid = 1'b0; rd_ready = 1'b0;
        chk("t4_cnt0", 32'(count0), 32'd3);
        chk("t4_cnt1", 32'(count1), 32'd4);
        chk("t4_drop1", 32'(drop1), 32'd2);
        chk("t4_rdy0", 32'(wr_ready0), 32'd1);
        // Held write now accepted in stall mode; dropped in drop mode.
        wr_valid = 1'b1; wr_data = 14'h1AB;
        step();
        wr_valid = 1'b0;
        chk("t4_cnt0_refill", 32'(count0), 32'd4);
        chk("t4_drop1_nopop", 32'(drop1), 32'd3);
        chk("t4_drop0_stall", 32'(drop0), 32'd0);
        exp0[0] = 14'h102; exp0[1] = 14'h103; exp0[2] = 14'h104; exp0[3] = 14'h1AB;
        exp1[0] = 14'h102; exp1[1] = 14'h103; exp1[2] = 14'h104; exp1[3] = 14'h1AA;
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_drain0_%0d", i), 32'(rd_data0), 32'(exp0[i]));
            chk($sformatf("t4_drain1_%0d", i), 32'(rd_data1), 32'(exp1[i]));
            step();
        end
        rd_ready = 1'b0;
        chk("t4_empty0", 32'(empty0), 32'd1);
        chk("t4_empty1", 32'(empty1), 32'd1);

        // ---- 5: ten writes with interleaved pops, pointers wrap ----
        wr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_data  = DW'(14'h200 + i);
            rd_ready = (i >= 2);
            if (i >= 2) begin
                chk($sformatf("t5_seq0_%0d", i - 2), 32'(rd_data0), 32'(14'h200 + i - 2));
                chk($sformatf("t5_seq1_%0d", i - 2), 32'(rd_data1), 32'(14'h200 + i - 2));
            end
            step();
        end
        wr_valid = 1'b0;
        chk("t5_cnt0_mid", 32'(count0), 32'd2);
        chk("t5_tail0_a", 32'(rd_data0), 32'h208); step();
        chk("t5_tail0_b", 32'(rd_data0), 32'h209);
        chk("t5_tail1_b", 32'(rd_data1), 32'h209); step();
        rd_ready = 1'b0;
        chk("t5_empty0", 32'(empty0), 32'd1);

        // ---- 6: flush with concurrent write/read, then reset mid-stream ----
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = DW'(14'h301 + i);
            step();
        end
        chk("t6_cnt0_pre", 32'(count0), 32'd3);
        flush = 1'b1; wr_data = 14'h3FF; rd_ready = 1'b1;
        step();
        flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        chk("t6_empty0", 32'(empty0), 32'd1);
        chk("t6_empty1", 32'(empty1), 32'd1);
        chk("t6_data0", 32'(rd_data0), 32'd0);
        chk("t6_cnt1", 32'(count1), 32'd0);
        chk("t6_drop1_kept", 32'(drop1), 32'd3);
        wr_valid = 1'b1; wr_data = 14'h3AA;
        step();
        chk("t6_after_flush0", 32'(rd_data0), 32'h3AA);
        chk("t6_after_flush_cnt1", 32'(count1), 32'd1);
        wr_data = 14'h3AB; step();
        rst_n = 1'b0; wr_data = 14'h3AC; rd_ready = 1'b1;
        step();
        rst_n = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0;
        chk_reset_state("t6_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
